fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one fp_mul instance between N_REQ requesters, e.g. the unit-converter conversion channels.
- Picks requesters round-robin, drives the operands and the start pulse, waits for done, then returns the product to the owning requester.
- Sits between the channel controllers and the single multiplier, so each channel never drives fp_mul directly.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 64, WAIT-state watchdog limit in clk cycles. Used only when FP_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock; all arbiter logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held high until gnt.
- req_a  in  32*N_REQ  operand 1 per requester (IEEE 754 single), slice i = [32i+31:32i].
- req_b  in  32*N_REQ  operand 2 per requester, same packing.
- gnt  out  N_REQ  one-hot, one-cycle pulse: operands captured.
- rsp_valid  out  N_REQ  one-hot, one-cycle pulse: rsp_data valid for that requester.
- rsp_data  out  32  product (IEEE 754 single).
- mul_num1  out  32  to fp_mul num1.
- mul_num2  out  32  to fp_mul num2.
- mul_start  out  1  to fp_mul start.
- mul_out  in  32  from fp_mul num_out.
- mul_done  in  1  from fp_mul done.
- mul_rst  out  1  to fp_mul rst, OR'd with system rst at top level.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse on watchdog timeout.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and last_ptr = N_REQ-1, so requester 0 wins first.
- IDLE:
  - If req is nonzero, choose the first set bit scanning upward from last_ptr+1, wrapping modulo N_REQ.
  - Latch that requester's operands into mul_num1/mul_num2, pulse gnt[i], store owner = i, then go to ISSUE.
  - If req is zero, stay in IDLE.
- ISSUE: assert mul_start for exactly one cycle, then go to WAIT.
  - fp_mul samples start on the falling edge inside this cycle.
- WAIT:
  - Hold mul_num1/mul_num2 stable.
  - On a rising edge where mul_done = 1, capture mul_out into rsp_data and go to RESP.
  - mul_done is one full clk period wide, so it is seen exactly once.
- RESP: pulse rsp_valid[owner], set last_ptr = owner, return to IDLE.
- rsp_data holds its value until the next capture.
- Latency:
  - req to gnt is 1 cycle.
  - gnt to mul_start is 1 cycle.
  - mul_start to mul_done is fp_mul latency: 6 cycles plus 1 per normalize shift.
  - mul_done to rsp_valid is 1 cycle.
  - Minimum request-to-request turnaround is 1 idle cycle after RESP.
- Fairness: a requester holding req is granted within N_REQ transactions.
- Requester rules:
  - A req that drops before its gnt is ignored and nothing is recorded.
  - Operands are sampled only in the gnt cycle; later changes have no effect.
  - req still high in the cycle after gnt is treated as a new request.
- Simultaneous events:
  - The owner's req and other reqs during ISSUE, WAIT or RESP are not arbitrated until IDLE.
  - rsp_valid and a new gnt never occur in the same cycle.
- A mul_done outside WAIT is ignored.
- Reset mid-operation: an in-flight transaction is abandoned and no rsp_valid is issued. fp_mul is reset by the shared rst.
- gnt, rsp_valid, mul_start and err are never high for more than one consecutive cycle.

Optional Feature:
- FP_ARB_TIMEOUT_EN defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - On reaching TIMEOUT_CYC without mul_done, the block pulses err and mul_rst for one cycle.
  - It then sets rsp_data = 32'h7FC00000 (qNaN) and goes to RESP, so the owner still receives rsp_valid.
- FP_ARB_TIMEOUT_EN undefined: no counter, mul_rst and err are tied 0, and WAIT has no limit.

Decomposition:
- Package fp_arb_pkg:
  - state encoding: IDLE=0, ISSUE=1, WAIT=2, RESP=3;
  - FP_QNAN = 32'h7FC00000;
  - FP_W = 32.
- One combinational sub-module, rr_pick: inputs req and last_ptr; outputs one-hot grant, encoded index and any.

Test Plan:
- req=0001, a=0x40000000 (2.0), b=0x40400000 (3.0) -> gnt[0] next cycle; rsp_valid[0] with rsp_data=0x40C00000.
- req=1111 held continuously, all operands 0x3FC00000 -> grants in order 0,1,2,3,0; every rsp_data=0x40100000.
- req[2] only, a=0xC0000000, b=0x3F000000 -> rsp_valid=0100, rsp_data=0xBF800000; mul_num1/mul_num2 stable through WAIT.
- rst asserted during WAIT -> all outputs 0 next cycle, no rsp_valid; a following request to requester 0 completes normally.
- req[1] pulsed for 1 cycle while busy -> no gnt[1]; req[3] held -> served after the current RESP.
- FP_ARB_TIMEOUT_EN with mul_done forced 0, TIMEOUT_CYC=64 -> err and mul_rst pulse 64 cycles after entering WAIT; rsp_data=0x7FC00000 with rsp_valid to the owner.

Source files
------------

// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp_mul arbiter: FSM state encoding,
// IEEE 754 single-precision width and the quiet-NaN returned on a timeout.
package fp_arb_pkg;

    localparam int FP_W = 32;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/fp_mul_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_ptr+1, wrapping modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    int          cand_int;
    logic [IW-1:0] cand;

    always_comb begin
        idx      = '0;
        any      = 1'b0;
        cand_int = 0;
        cand     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_int = (int'(last_ptr) + k) % N_REQ;
            cand     = IW'(cand_int);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign grant[gi] = any && (idx == IW'(gi));
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one fp_mul between N_REQ requesters.
// Optional WAIT watchdog enabled by defining FP_ARB_TIMEOUT_EN.
module fp_mul_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_data,
    output logic [31:0]           mul_num1,
    output logic [31:0]           mul_num2,
    output logic                  mul_start,
    input  logic [31:0]           mul_out,
    input  logic                  mul_done,
    output logic                  mul_rst,
    output logic                  busy,
    output logic                  err
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("fp_mul_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("fp_mul_arbiter: TIMEOUT_CYC must be at least 1");
    end

    arb_state_t       state_reg;
    logic [IW-1:0]    last_ptr_reg;
    logic [IW-1:0]    owner_reg;
    logic [N_REQ-1:0] pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

`ifdef FP_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] wd_cnt_reg;
`endif

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .req      (req),
        .last_ptr (last_ptr_reg),
        .grant    (pick_onehot),
        .idx      (pick_idx),
        .any      (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_ptr_reg <= IW'(N_REQ - 1);
            owner_reg    <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            mul_num1     <= '0;
            mul_num2     <= '0;
            mul_start    <= 1'b0;
            busy         <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
            wd_cnt_reg   <= '0;
            err          <= 1'b0;
            mul_rst      <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low so each is high for one cycle only.
            gnt       <= '0;
            rsp_valid <= '0;
            mul_start <= 1'b0;
`ifdef FP_ARB_TIMEOUT_EN
            err       <= 1'b0;
            mul_rst   <= 1'b0;
`endif
            unique case (state_reg)
                IDLE: begin
                    if (pick_any) begin
                        mul_num1  <= req_a[pick_idx*FP_W +: FP_W];
                        mul_num2  <= req_b[pick_idx*FP_W +: FP_W];
                        gnt       <= pick_onehot;
                        owner_reg <= pick_idx;
                        busy      <= 1'b1;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b1;
                    state_reg <= WAIT;
`ifdef FP_ARB_TIMEOUT_EN
                    wd_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (mul_done) begin
                        rsp_data  <= mul_out;
                        state_reg <= RESP;
                    end
`ifdef FP_ARB_TIMEOUT_EN
                    else if (wd_cnt_reg == TW'(TIMEOUT_CYC - 1)) begin
                        // Multiplier hung: reset it and hand the owner a qNaN.
                        err       <= 1'b1;
                        mul_rst   <= 1'b1;
                        rsp_data  <= FP_QNAN;
                        state_reg <= RESP;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    rsp_valid    <= N_REQ'(1) << owner_reg;
                    last_ptr_reg <= owner_reg;
                    busy         <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifndef FP_ARB_TIMEOUT_EN
    assign err     = 1'b0;
    assign mul_rst = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Self-checking bench for fp_mul_arbiter with a behavioural fp_mul and a
// round-robin reference model. Define FP_ARB_TIMEOUT_EN to exercise the watchdog.
module tb_fp_mul_arbiter;

    localparam int N_REQ       = 4;
    localparam int TIMEOUT_CYC = 64;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req = '0;
    logic [32*N_REQ-1:0]  req_a = '0;
    logic [32*N_REQ-1:0]  req_b = '0;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     rsp_valid;
    logic [31:0]          rsp_data;
    logic [31:0]          mul_num1;
    logic [31:0]          mul_num2;
    logic                 mul_start;
    logic [31:0]          mul_out = '0;
    logic                 mul_done = 1'b0;
    logic                 mul_rst;
    logic                 busy;
    logic                 err;

    logic                 mul_hang = 1'b0;
    int                   tests_run = 0;
    int                   tests_failed = 0;
    int                   model_last = N_REQ - 1;

    fp_mul_arbiter #(
        .N_REQ       (N_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .mul_num1  (mul_num1),
        .mul_num2  (mul_num2),
        .mul_start (mul_start),
        .mul_out   (mul_out),
        .mul_done  (mul_done),
        .mul_rst   (mul_rst),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_watchdog: got no finish, required finish before 50000 cycles");
        $fatal(1, "bench time budget exhausted");
    end

    // ---------------- reference arithmetic (normal numbers only) ----------------
    function automatic real sp2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2sp(input real v);
        real         va;
        logic        s;
        int          e;
        logic [22:0] f;
        logic [7:0]  be;
        if (v == 0.0) return 32'h0;
        s  = (v < 0.0);
        va = s ? -v : v;
        e  = 0;
        while (va >= 2.0) begin va = va / 2.0; e++; end
        while (va < 1.0)  begin va = va * 2.0; e--; end
        f  = 23'($rtoi((va - 1.0) * 8388608.0));
        be = 8'(e + 127);
        return {s, be, f};
    endfunction

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) * sp2r(b));
    endfunction

    function automatic logic [31:0] rand_op();
        return {1'($urandom), 8'($urandom_range(110, 144)), 23'($urandom)};
    endfunction

    // Round-robin rule: first pending requester after the last one served.
    function automatic int model_pick(input logic [N_REQ-1:0] m, input int last);
        for (int k = 1; k <= N_REQ; k++) begin
            if (m[(last + k) % N_REQ]) return (last + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic int oh2i(input logic [N_REQ-1:0] v);
        for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ---------------- behavioural fp_mul: 6..8 cycle latency ----------------
    int          fm_cnt = 0;
    bit          fm_busy = 1'b0;
    logic [31:0] fm_a, fm_b;

    always @(negedge clk) begin
        if (rst || mul_rst) begin
            fm_busy  = 1'b0;
            mul_done = 1'b0;
        end else if (mul_done) begin
            mul_done = 1'b0;
        end else if (fm_busy) begin
            fm_cnt--;
            if (fm_cnt == 0) begin
                fm_busy  = 1'b0;
                mul_out  = fmul(fm_a, fm_b);
                mul_done = 1'b1;
            end
        end else if (mul_start && !mul_hang) begin
            fm_a    = mul_num1;
            fm_b    = mul_num2;
            fm_cnt  = 6 + int'($urandom_range(0, 2));
            fm_busy = 1'b1;
        end
    end

    // ---------------- stimulus / observation helpers (no checking) ----------------
    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_last = N_REQ - 1;
    endtask

    task automatic wait_gnt(input int budget, output logic [N_REQ-1:0] g);
        g = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (gnt != '0) begin g = gnt; return; end
        end
    endtask

    task automatic wait_rsp(input int budget, output logic [N_REQ-1:0] v, output logic [31:0] d);
        v = '0;
        d = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin v = rsp_valid; d = rsp_data; return; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [108:0] outs;
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        outs = {gnt, rsp_valid, rsp_data, mul_num1, mul_num2, mul_start, mul_rst, busy, err};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h, required 0", outs); end
        rst = 1'b0;
        model_last = N_REQ - 1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({busy, gnt} !== '0) begin tests_failed++; $display("FAIL idle_no_req: got busy/gnt %b, required 0", {busy, gnt}); end
    endtask

    task automatic test_single();
        logic [N_REQ-1:0] v;
        logic [31:0]      d;
        set_ops(0, 32'h4000_0000, 32'h4040_0000);
        req = 4'b0001;
        @(negedge clk);
        tests_run++;
        if (gnt !== 4'b0001) begin tests_failed++; $display("FAIL single_gnt_latency: got %b, required 0001", gnt); end
        req = '0;
        @(negedge clk);
        tests_run++;
        if ({mul_start, gnt} !== {1'b1, 4'b0000}) begin tests_failed++; $display("FAIL single_start: got start=%b gnt=%b, required start=1 gnt=0000", mul_start, gnt); end
        wait_rsp(40, v, d);
        tests_run++;
        if (v !== 4'b0001) begin tests_failed++; $display("FAIL single_rsp_valid: got %b, required 0001", v); end
        tests_run++;
        if (d !== 32'h40C0_0000) begin tests_failed++; $display("FAIL single_rsp_data: got %h, required 40c00000", d); end
        $display("[TB] txn single owner=0 data=%h", d);
        model_last = 0;
    endtask

    task automatic test_round_robin();
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        int n_g = 0;
        int n_r = 0;
        int owner = -1;
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_ops(i, 32'h3FC0_0000, 32'h3FC0_0000);
        req = '1;
        for (int c = 0; c < 300 && n_r < 5; c++) begin
            @(negedge clk);
            if (gnt != '0 && rsp_valid != '0) begin
                tests_run++; tests_failed++;
                $display("FAIL rr_gnt_rsp_overlap: got gnt=%b rsp=%b, required not both", gnt, rsp_valid);
            end
            if (gnt != '0 && n_g < 5) begin
                tests_run++;
                if (oh2i(gnt) !== exp_seq[n_g]) begin tests_failed++; $display("FAIL rr_order_%0d: got %0d, required %0d", n_g, oh2i(gnt), exp_seq[n_g]); end
                owner = exp_seq[n_g];
                n_g++;
            end
            if (rsp_valid != '0) begin
                tests_run++;
                if ({rsp_valid, rsp_data} !== {N_REQ'(1) << owner, 32'h4010_0000}) begin
                    tests_failed++;
                    $display("FAIL rr_rsp_%0d: got %b/%h, required %b/40100000", n_r, rsp_valid, rsp_data, N_REQ'(1) << owner);
                end
                $display("[TB] txn rr owner=%0d data=%h", oh2i(rsp_valid), rsp_data);
                n_r++;
                if (n_r == 5) req = '0;
            end
        end
        tests_run++;
        if (n_r !== 5) begin tests_failed++; $display("FAIL rr_count: got %0d responses, required 5", n_r); end
        model_last = 0;
    endtask

    task automatic test_operand_stable();
        logic [N_REQ-1:0] g;
        int bad = 0;
        int cyc = 0;
        set_ops(2, 32'hC000_0000, 32'h3F00_0000);
        req = 4'b0100;
        wait_gnt(10, g);
        tests_run++;
        if (g !== 4'b0100) begin tests_failed++; $display("FAIL stable_gnt: got %b, required 0100", g); end
        req = '0;
        set_ops(2, rand_op(), rand_op());
        while (rsp_valid == '0 && cyc < 40) begin
            if (mul_num1 !== 32'hC000_0000 || mul_num2 !== 32'h3F00_0000) bad++;
            @(negedge clk);
            cyc++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL stable_operands: got %0d unstable cycles, required 0", bad); end
        tests_run++;
        if ({rsp_valid, rsp_data} !== {4'b0100, 32'hBF80_0000}) begin tests_failed++; $display("FAIL stable_rsp: got %b/%h, required 0100/bf800000", rsp_valid, rsp_data); end
        $display("[TB] txn stable owner=2 data=%h", rsp_data);
        model_last = 2;
    endtask

    task automatic test_reset_mid();
        logic [N_REQ-1:0] g, v;
        logic [31:0]      d;
        logic [108:0]     outs;
        int               stray = 0;
        set_ops(1, rand_op(), rand_op());
        req = 4'b0010;
        wait_gnt(10, g);
        req = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        outs = {gnt, rsp_valid, rsp_data, mul_num1, mul_num2, mul_start, mul_rst, busy, err};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL midreset_outputs: got %h, required 0", outs); end
        @(negedge clk);
        rst = 1'b0;
        model_last = N_REQ - 1;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid != '0) stray++;
        end
        tests_run++;
        if (stray !== 0) begin tests_failed++; $display("FAIL midreset_no_rsp: got %0d rsp pulses, required 0", stray); end
        set_ops(0, 32'h4000_0000, 32'h4040_0000);
        req = 4'b0001;
        wait_gnt(10, g);
        req = '0;
        tests_run++;
        if (g !== 4'b0001) begin tests_failed++; $display("FAIL midreset_regnt: got %b, required 0001", g); end
        wait_rsp(40, v, d);
        tests_run++;
        if ({v, d} !== {4'b0001, 32'h40C0_0000}) begin tests_failed++; $display("FAIL midreset_rsp: got %b/%h, required 0001/40c00000", v, d); end
        $display("[TB] txn after_reset owner=0 data=%h", d);
        model_last = 0;
    endtask

    task automatic test_pulse_ignore();
        logic [N_REQ-1:0] g, v;
        logic [31:0]      d;
        int rsp_at = -1;
        int gnt_at = -1;
        logic [N_REQ-1:0] g2 = '0;
        set_ops(0, 32'h3F80_0000, 32'h4000_0000);
        set_ops(1, 32'h4000_0000, 32'h4000_0000);
        set_ops(3, 32'h4080_0000, 32'h3F00_0000);
        req = 4'b0001;
        wait_gnt(10, g);
        req = '0;
        @(negedge clk);
        req = 4'b0010;
        @(negedge clk);
        req = 4'b1000;
        for (int c = 0; c < 60 && gnt_at < 0; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) rsp_at = c;
            if (gnt != '0) begin gnt_at = c; g2 = gnt; req = '0; end
        end
        tests_run++;
        if (g2 !== 4'b1000) begin tests_failed++; $display("FAIL pulse_next_gnt: got %b, required 1000", g2); end
        tests_run++;
        if (gnt_at - rsp_at !== 1) begin tests_failed++; $display("FAIL pulse_turnaround: got %0d cycles rsp->gnt, required 1", gnt_at - rsp_at); end
        wait_rsp(40, v, d);
        tests_run++;
        if ({v, d} !== {4'b1000, 32'h4000_0000}) begin tests_failed++; $display("FAIL pulse_rsp3: got %b/%h, required 1000/40000000", v, d); end
        $display("[TB] txn pulse owner=3 data=%h", d);
        model_last = 3;
    endtask

    task automatic test_random();
        logic [31:0]      ra [N_REQ];
        logic [31:0]      rb [N_REQ];
        logic [N_REQ-1:0] mask = '0;
        logic [31:0]      exp_prod = '0;
        int               owner = -1;
        int               done_cnt = 0;
        int               exp_i;
        int               idle_cyc = 0;
        do_reset();
        for (int c = 0; c < 3000 && done_cnt < 25; c++) begin
            @(negedge clk);
            if (gnt != '0 && rsp_valid != '0) begin
                tests_run++; tests_failed++;
                $display("FAIL rand_gnt_rsp_overlap: got gnt=%b rsp=%b, required not both", gnt, rsp_valid);
            end
            if (gnt != '0) begin
                exp_i = model_pick(mask, model_last);
                tests_run++;
                if (exp_i < 0 || gnt !== (N_REQ'(1) << exp_i)) begin tests_failed++; $display("FAIL rand_gnt: got %b, required index %0d", gnt, exp_i); end
                if (exp_i >= 0) begin
                    tests_run++;
                    if ({mul_num1, mul_num2} !== {ra[exp_i], rb[exp_i]}) begin tests_failed++; $display("FAIL rand_operands: got %h/%h, required %h/%h", mul_num1, mul_num2, ra[exp_i], rb[exp_i]); end
                    exp_prod = fmul(ra[exp_i], rb[exp_i]);
                    owner = exp_i;
                    mask[exp_i] = 1'b0;
                    set_ops(exp_i, rand_op(), rand_op());
                end
            end
            if (rsp_valid != '0) begin
                tests_run++;
                if (owner < 0 || {rsp_valid, rsp_data} !== {N_REQ'(1) << owner, exp_prod}) begin
                    tests_failed++;
                    $display("FAIL rand_rsp: got %b/%h, required owner %0d/%h", rsp_valid, rsp_data, owner, exp_prod);
                end
                $display("[TB] txn rand owner=%0d data=%h", owner, rsp_data);
                model_last = owner;
                done_cnt++;
            end
            if (done_cnt < 25) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!mask[i] && $urandom_range(0, 3) == 0) begin
                        ra[i] = rand_op();
                        rb[i] = rand_op();
                        set_ops(i, ra[i], rb[i]);
                        mask[i] = 1'b1;
                    end
                end
                req = mask;
            end else begin
                req = '0;
            end
        end
        tests_run++;
        if (done_cnt !== 25) begin tests_failed++; $display("FAIL rand_count: got %0d responses, required 25", done_cnt); end
        while (busy && idle_cyc < 50) begin @(negedge clk); idle_cyc++; end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL rand_drain: got busy=%b, required 0", busy); end
    endtask

`ifdef FP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [N_REQ-1:0] g;
        int cnt = 0;
        mul_hang = 1'b1;
        set_ops(0, rand_op(), rand_op());
        req = 4'b0001;
        wait_gnt(10, g);
        req = '0;
        @(negedge clk);
        tests_run++;
        if (mul_start !== 1'b1) begin tests_failed++; $display("FAIL timeout_start: got %b, required 1", mul_start); end
        while (err !== 1'b1 && cnt < 200) begin @(negedge clk); cnt++; end
        tests_run++;
        if (cnt !== TIMEOUT_CYC) begin tests_failed++; $display("FAIL timeout_delay: got %0d cycles, required %0d", cnt, TIMEOUT_CYC); end
        tests_run++;
        if (mul_rst !== 1'b1) begin tests_failed++; $display("FAIL timeout_mul_rst: got %b, required 1", mul_rst); end
        @(negedge clk);
        tests_run++;
        if ({err, mul_rst, rsp_valid, rsp_data} !== {2'b00, 4'b0001, 32'h7FC0_0000}) begin
            tests_failed++;
            $display("FAIL timeout_rsp: got err=%b mul_rst=%b %b/%h, required 0 0 0001/7fc00000", err, mul_rst, rsp_valid, rsp_data);
        end
        $display("[TB] txn timeout owner=0 data=%h", rsp_data);
        mul_hang = 1'b0;
        model_last = 0;
    endtask
`else
    task automatic test_no_timeout();
        logic [N_REQ-1:0] g;
        int flags = 0;
        set_ops(1, 32'h3F80_0000, 32'h3F80_0000);
        req = 4'b0010;
        wait_gnt(10, g);
        req = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (err || mul_rst) flags++;
        end
        tests_run++;
        if (flags !== 0) begin tests_failed++; $display("FAIL no_timeout_flags: got %0d err/mul_rst cycles, required 0", flags); end
        model_last = 1;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_operand_stable();
        test_reset_mid();
        test_pulse_ignore();
        test_random();
`ifdef FP_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
